// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: segment patterns
// (active-low {a,b,c,d,e,f,g}) and the scan state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0001100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b1110010;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low 7-segment pattern; purely combinational,
// no handshake.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEG_BLANK;
    unique case (nibble)
      4'h0: segs = SEG_0;
      4'h1: segs = SEG_1;
      4'h2: segs = SEG_2;
      4'h3: segs = SEG_3;
      4'h4: segs = SEG_4;
      4'h5: segs = SEG_5;
      4'h6: segs = SEG_6;
      4'h7: segs = SEG_7;
      4'h8: segs = SEG_8;
      4'h9: segs = SEG_9;
      4'hA: segs = SEG_A;
      4'hB: segs = SEG_B;
      4'hC: segs = SEG_C;
      4'hD: segs = SEG_D;
      4'hE: segs = SEG_E;
      4'hF: segs = SEG_F;
      default: segs = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed NDIG-digit common-anode display scanner; registered pins.
// New contents land in a one-deep pending buffer and reach the display only at frame wrap.
module seg_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] load_data,
  input  logic [NDIG-1:0]   load_en,
  input  logic [NDIG-1:0]   load_dp,
  input  logic              load_valid,
  output logic              load_ready,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        segs,
  output logic              dp,
  output logic              frame_sync
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIG);

  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  scan_state_t       state, state_nxt;
  logic              slot_end, frame_end;

  logic [4*NDIG-1:0] disp_data, pend_data;
  logic [NDIG-1:0]   disp_en, pend_en, disp_dp, pend_dp;
  logic              pend_full;

  logic [3:0]        cur_nibble;
  logic [6:0]        dec_segs;
  logic [NDIG-1:0]   an_nxt;
  logic [6:0]        segs_nxt;
  logic              dp_nxt;

  assign load_ready = ~pend_full;

  // Decode the digit that will be on the pins after this edge.
  assign cur_nibble = disp_data[4*idx_nxt +: 4];

  seg7_hex_decode u_dec (
    .nibble (cur_nibble),
    .segs   (dec_segs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    slot_end  = (cnt == CW'(SCAN_DIV - 1));
    frame_end = slot_end && (idx == IW'(NDIG - 1));
    if (slot_end) begin
      cnt_nxt = '0;
      idx_nxt = frame_end ? '0 : idx + 1'b1;
    end

    state_nxt = state;
    unique case (state)
      BLANK:   if (cnt_nxt == CW'(BLANK_CYC)) state_nxt = SHOW;
      SHOW:    if (slot_end) state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase

    // A disabled digit stays fully dark for its whole slot.
    an_nxt   = '1;
    segs_nxt = SEG_BLANK;
    dp_nxt   = 1'b1;
    if (state_nxt == SHOW && disp_en[idx_nxt]) begin
      an_nxt[idx_nxt] = 1'b0;
      segs_nxt        = dec_segs;
      dp_nxt          = ~disp_dp[idx_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      an         <= '1;
      segs       <= SEG_BLANK;
      dp         <= 1'b1;
      frame_sync <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      an         <= an_nxt;
      segs       <= segs_nxt;
      dp         <= dp_nxt;
      frame_sync <= frame_end;
    end
  end

  // Pending full blocks new loads, so a boundary copy and an accept never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_data <= '0;
      pend_en   <= '0;
      pend_dp   <= '0;
      disp_data <= '0;
      disp_en   <= '0;
      disp_dp   <= '0;
    end else if (frame_end && pend_full) begin
      disp_data <= pend_data;
      disp_en   <= pend_en;
      disp_dp   <= pend_dp;
      pend_full <= 1'b0;
    end else if (load_valid && !pend_full) begin
      pend_data <= load_data;
      pend_en   <= load_en;
      pend_dp   <= load_dp;
      pend_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (NDIG=4, SCAN_DIV=8, BLANK_CYC=2): per-cycle scoreboard
// of expected pin values plus directed spot checks of hand-decoded patterns.
module tb_seg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = NDIG * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] load_data = '0;
  logic [3:0]  load_en = '0;
  logic [3:0]  load_dp = '0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [3:0]  an;
  logic [6:0]  segs;
  logic        dp;
  logic        frame_sync;

  seg_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_data  (load_data),
    .load_en    (load_en),
    .load_dp    (load_dp),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .an         (an),
    .segs       (segs),
    .dp         (dp),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] segs;
    logic       dp;
    logic       fs;
    logic       rdy;
  } obs_t;

  localparam obs_t RST_OBS = '{an: 4'hF, segs: 7'h7F, dp: 1'b1, fs: 1'b0, rdy: 1'b1};

  logic [6:0] tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000};

  obs_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference: position derived from cycles since reset, contents from a shadow buffer.
  int          m_t;
  bit          m_pf, m_bnd;
  logic [15:0] m_dd, m_pd;
  logic [3:0]  m_de, m_pe, m_ddp, m_pdp;
  int          m_p, m_s;
  obs_t        m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_pf = 0; m_dd = '0; m_de = '0; m_ddp = '0;
      sb_q.delete();
    end else begin
      m_bnd = ((m_t % FRAME) == FRAME - 1);
      if (m_bnd && m_pf) begin
        m_dd = m_pd; m_de = m_pe; m_ddp = m_pdp; m_pf = 0;
      end else if (load_valid && !m_pf) begin
        m_pd = load_data; m_pe = load_en; m_pdp = load_dp; m_pf = 1;
      end
      m_t++;
      m_p = m_t % SD;
      m_s = (m_t / SD) % NDIG;
      m_e = '{an: 4'hF, segs: 7'h7F, dp: 1'b1, fs: m_bnd, rdy: !m_pf};
      if (m_p >= BC && m_de[m_s]) begin
        m_e.an[m_s] = 1'b0;
        m_e.segs    = tbl[m_dd[4*m_s +: 4]];
        m_e.dp      = ~m_ddp[m_s];
      end
      sb_q.push_back(m_e);
    end
  end

  always @(negedge clk) begin
    obs_t e, a;
    a = {an, segs, dp, frame_sync, load_ready};
    if (!rst_n || sb_q.size() == 0) e = RST_OBS;
    else e = sb_q.pop_front();
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL scan @%0t: got an=%b segs=%b dp=%b fs=%b rdy=%b, expected an=%b segs=%b dp=%b fs=%b rdy=%b",
               $time, a.an, a.segs, a.dp, a.fs, a.rdy, e.an, e.segs, e.dp, e.fs, e.rdy);
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(input string nm);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (frame_sync === 1'b1) break;
    end
    chk(nm, {15'd0, frame_sync}, 16'd1);
  endtask

  task automatic do_load(input string nm, input logic [15:0] d, input logic [3:0] e, input logic [3:0] p);
    load_data  = d;
    load_en    = e;
    load_dp    = p;
    load_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (load_ready === 1'b1) break;
      @(negedge clk);
    end
    chk(nm, {15'd0, load_ready}, 16'd1);
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = 16'hDEAD;
    load_en    = 4'hA;
    load_dp    = 4'h5;
  endtask

  initial begin
    int n;
    skip(3);
    rst_n = 1'b1;

    // 1: idle after reset
    skip(5);
    chk("t1_an", {12'd0, an}, 16'h000F);
    wait_fs("t1_fs");
    chk("t1_rdy", {15'd0, load_ready}, 16'd1);

    // 2: digits 0..3 show 0,1,2,3
    do_load("t2_load", 16'h3210, 4'hF, 4'h0);
    wait_fs("t2_fs");
    skip(1); chk("t2_blank_an", {12'd0, an}, 16'h000F);
    skip(1); chk("t2_s0_an", {12'd0, an}, 16'h000E);
             chk("t2_s0_segs", {9'd0, segs}, 16'(7'b0000001));
    skip(6); chk("t2_s1_blank", {12'd0, an}, 16'h000F);
    skip(18); chk("t2_s3_an", {12'd0, an}, 16'h0007);
             chk("t2_s3_segs", {9'd0, segs}, 16'(7'b0000110));

    // 3: 8, A, F with decimal point on digit 1
    do_load("t3_load", 16'hFBA8, 4'hF, 4'b0010);
    wait_fs("t3_fs");
    skip(2); chk("t3_s0_segs", {9'd0, segs}, 16'(7'b0000000));
    skip(7); chk("t3_s1_blank_dp", {15'd0, dp}, 16'd1);
    skip(1); chk("t3_s1_segs", {9'd0, segs}, 16'(7'b0001000));
             chk("t3_s1_dp", {15'd0, dp}, 16'd0);
    skip(16); chk("t3_s3_segs", {9'd0, segs}, 16'(7'b0111000));

    // 4: back-to-back loads, second one held while the buffer is full
    do_load("t4_loadA", 16'h4567, 4'hF, 4'h0);
    load_data  = 16'h89AB;
    load_en    = 4'hF;
    load_dp    = 4'h0;
    load_valid = 1'b1;
    chk("t4_rdy_low", {15'd0, load_ready}, 16'd0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (load_ready === 1'b1) break;
    end
    chk("t4_rdy_at_fs", {15'd0, frame_sync}, 16'd1);
    @(negedge clk);
    load_valid = 1'b0;
    chk("t4_B_taken", {15'd0, load_ready}, 16'd0);
    skip(1); chk("t4_A_shown", {9'd0, segs}, 16'(7'b0001111));
    wait_fs("t4_fs");
    skip(2); chk("t4_B_s0", {9'd0, segs}, 16'(7'b1100000));
    skip(8); chk("t4_B_s1", {9'd0, segs}, 16'(7'b0001000));

    // 5: only digits 0 and 2 lit; frame length unchanged
    do_load("t5_load", 16'h3210, 4'b0101, 4'h0);
    wait_fs("t5_fs");
    skip(13); chk("t5_s1_dark", {12'd0, an}, 16'h000F);
    skip(8);  chk("t5_s2_lit", {12'd0, an}, 16'h000B);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_sync !== 1'b1 && n < 3 * FRAME);
    wait_fs("t5_fs2");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_sync !== 1'b1 && n < 3 * FRAME);
    chk("t5_period", 16'(n), 16'(FRAME));

    // 6: async reset mid-SHOW of slot 2 with a load pending
    do_load("t6_load", 16'h1111, 4'hF, 4'hF);
    skip(19);
    chk("t6_pre_an", {12'd0, an}, 16'h000B);
    chk("t6_pre_rdy", {15'd0, load_ready}, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_an", {12'd0, an}, 16'h000F);
    chk("t6_rst_segs", {9'd0, segs}, 16'h007F);
    chk("t6_rst_dp_rdy", {14'd0, dp, load_ready}, 16'd3);
    skip(2);
    rst_n = 1'b1;
    wait_fs("t6_fs");
    skip(10);
    chk("t6_blank_an", {12'd0, an}, 16'h000F);
    chk("t6_rdy", {15'd0, load_ready}, 16'd1);
    skip(FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
